// File: rtl/sc_tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: channel count,
// channel FSM state and the periodic/one-shot mode encoding.
package sc_tick_scheduler_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running base prescaler: counts up from 0 and strobes whenever the
// count has reached or passed the terminal value, then returns to 0.
module sc_tick_prescaler #(
  parameter int BASE_WIDTH = 27
) (
  input  logic                  SC_COUNTER_CLOCK_50,
  input  logic                  SC_COUNTER_RESET_InLow,
  input  logic                  clear_n_i,
  input  logic [BASE_WIDTH-1:0] base_top_i,
  output logic                  strobe_o
);

  logic [BASE_WIDTH-1:0] count_q;
  logic [BASE_WIDTH-1:0] count_d;
  logic                  hit;

  // ">=" rather than "==" so lowering the terminal below the count wraps at once
  assign hit      = (count_q >= base_top_i);
  assign strobe_o = clear_n_i && hit;

  always_comb begin
    count_d = count_q + BASE_WIDTH'(1);
    if (!clear_n_i || hit) begin
      count_d = '0;
    end
  end

  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sc_tick_scheduler.sv
// Four-channel tick scheduler: each channel counts base strobes and emits a
// one-cycle active-low tick every (div+1) strobes, periodically or once.
module sc_tick_scheduler
  import sc_tick_scheduler_pkg::*;
#(
  parameter int BASE_WIDTH = 27,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  SC_COUNTER_CLOCK_50,
  input  logic                  SC_COUNTER_RESET_InLow,
  input  logic                  SC_TICKSCHED_clear_InLow,
  input  logic [BASE_WIDTH-1:0] SC_TICKSCHED_baseTop_InBUS,
  input  logic                  SC_TICKSCHED_load_InLow,
  input  logic [1:0]            SC_TICKSCHED_loadSel_InBUS,
  input  logic [DIV_WIDTH-1:0]  SC_TICKSCHED_loadDiv_InBUS,
  input  logic                  SC_TICKSCHED_loadMode_In,
  input  logic [3:0]            SC_TICKSCHED_start_InLow,
  input  logic [3:0]            SC_TICKSCHED_stop_InLow,
  output logic [3:0]            SC_TICKSCHED_tick_OutLow,
  output logic [3:0]            SC_TICKSCHED_busy_Out,
  output logic                  SC_TICKSCHED_baseTick_Out
);

  logic                              strobe;
  logic                              base_tick_q;
  logic [NCH-1:0][DIV_WIDTH-1:0]     div_q;
  logic [NCH-1:0]                    mode_q;
  logic [NCH-1:0]                    tick_n;
  logic [NCH-1:0]                    run;

  sc_tick_prescaler #(
    .BASE_WIDTH (BASE_WIDTH)
  ) u_prescaler (
    .SC_COUNTER_CLOCK_50    (SC_COUNTER_CLOCK_50),
    .SC_COUNTER_RESET_InLow (SC_COUNTER_RESET_InLow),
    .clear_n_i              (SC_TICKSCHED_clear_InLow),
    .base_top_i             (SC_TICKSCHED_baseTop_InBUS),
    .strobe_o               (strobe)
  );

  // Base strobe is delayed one cycle so it lines up with the channel ticks
  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      base_tick_q <= 1'b0;
    end else begin
      base_tick_q <= strobe;
    end
  end

  // Configuration survives a clear; only reset returns it to defaults
  always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
    if (!SC_COUNTER_RESET_InLow) begin
      div_q  <= '0;
      mode_q <= {NCH{MODE_PERIODIC}};
    end else if (SC_TICKSCHED_clear_InLow && !SC_TICKSCHED_load_InLow) begin
      div_q[SC_TICKSCHED_loadSel_InBUS]  <= SC_TICKSCHED_loadDiv_InBUS;
      mode_q[SC_TICKSCHED_loadSel_InBUS] <= SC_TICKSCHED_loadMode_In;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ch_state_e             state_q;
    logic [DIV_WIDTH-1:0]  rem_q;
    logic                  tick_n_q;
    logic                  sel_load;
    logic [DIV_WIDTH-1:0]  start_div;

    // A start coinciding with a write to this channel picks up the new value
    assign sel_load  = !SC_TICKSCHED_load_InLow && (SC_TICKSCHED_loadSel_InBUS == 2'(g));
    assign start_div = sel_load ? SC_TICKSCHED_loadDiv_InBUS : div_q[g];

    always_ff @(posedge SC_COUNTER_CLOCK_50 or negedge SC_COUNTER_RESET_InLow) begin
      if (!SC_COUNTER_RESET_InLow) begin
        state_q  <= IDLE;
        rem_q    <= '0;
        tick_n_q <= 1'b1;
      end else begin
        tick_n_q <= 1'b1;
        if (!SC_TICKSCHED_clear_InLow) begin
          state_q <= IDLE;
          rem_q   <= '0;
        end else if (!SC_TICKSCHED_stop_InLow[g]) begin
          state_q <= IDLE;
        end else if (!SC_TICKSCHED_start_InLow[g]) begin
          state_q <= RUN;
          rem_q   <= start_div;
        end else if (state_q == RUN && strobe) begin
          if (rem_q != '0) begin
            rem_q <= rem_q - DIV_WIDTH'(1);
          end else begin
            tick_n_q <= 1'b0;
            if (mode_q[g] == MODE_ONESHOT) begin
              state_q <= IDLE;
            end else begin
              rem_q <= div_q[g];
            end
          end
        end
      end
    end

    assign tick_n[g] = tick_n_q;
    assign run[g]    = (state_q == RUN);
  end

  assign SC_TICKSCHED_tick_OutLow  = tick_n;
  assign SC_TICKSCHED_busy_Out     = run;
  assign SC_TICKSCHED_baseTick_Out = base_tick_q;

endmodule

// File: tb/tb_sc_tick_scheduler.sv
// Bench for sc_tick_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_sc_tick_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear_n = 1'b1;
  logic [26:0] base_top = '0;
  logic        load_n = 1'b1;
  logic [1:0]  load_sel = '0;
  logic [7:0]  load_div = '0;
  logic        load_mode = 1'b0;
  logic [3:0]  start_n = 4'hF;
  logic [3:0]  stop_n = 4'hF;
  logic [3:0]  tick_n;
  logic [3:0]  busy;
  logic        base_tick;

  int vec  = 0;
  int miss = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  int       m_cnt = 0;
  bit       m_run[4];
  int       m_rem[4];
  int       m_div[4];
  bit       m_mode[4];
  logic [3:0] e_tick = 4'hF;
  logic [3:0] e_busy = 4'h0;
  logic       e_base = 1'b0;

  sc_tick_scheduler #(.BASE_WIDTH(27), .DIV_WIDTH(8)) dut (
    .SC_COUNTER_CLOCK_50        (clk),
    .SC_COUNTER_RESET_InLow     (rst_n),
    .SC_TICKSCHED_clear_InLow   (clear_n),
    .SC_TICKSCHED_baseTop_InBUS (base_top),
    .SC_TICKSCHED_load_InLow    (load_n),
    .SC_TICKSCHED_loadSel_InBUS (load_sel),
    .SC_TICKSCHED_loadDiv_InBUS (load_div),
    .SC_TICKSCHED_loadMode_In   (load_mode),
    .SC_TICKSCHED_start_InLow   (start_n),
    .SC_TICKSCHED_stop_InLow    (stop_n),
    .SC_TICKSCHED_tick_OutLow   (tick_n),
    .SC_TICKSCHED_busy_Out      (busy),
    .SC_TICKSCHED_baseTick_Out  (base_tick)
  );

  // ---------------- clock / reset ----------------
  initial forever #10 clk = ~clk;

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss + 1);
    $fatal(1);
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 1'b0; m_rem[i] = 0; m_div[i] = 0; m_mode[i] = 1'b0;
    end
    e_tick = 4'hF; e_busy = 4'h0; e_base = 1'b0;
  endtask

  task automatic model_step();
    bit strobe;
    int eff;
    strobe = (m_cnt >= int'(base_top));
    e_tick = 4'hF;
    if (!clear_n) begin
      m_cnt  = 0;
      e_base = 1'b0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 1'b0; m_rem[i] = 0; end
    end else begin
      e_base = strobe;
      m_cnt  = strobe ? 0 : m_cnt + 1;
      for (int i = 0; i < 4; i++) begin
        eff = (!load_n && int'(load_sel) == i) ? int'(load_div) : m_div[i];
        if (!stop_n[i]) begin
          m_run[i] = 1'b0;
        end else if (!start_n[i]) begin
          m_run[i] = 1'b1;
          m_rem[i] = eff;
        end else if (m_run[i] && strobe) begin
          if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
          else begin
            e_tick[i] = 1'b0;
            if (m_mode[i]) m_run[i] = 1'b0;
            else m_rem[i] = m_div[i];
          end
        end
      end
      if (!load_n) begin
        m_div[load_sel]  = int'(load_div);
        m_mode[load_sel] = load_mode;
      end
    end
    for (int i = 0; i < 4; i++) e_busy[i] = m_run[i];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      vec++;
      if ({tick_n, busy, base_tick} !== {e_tick, e_busy, e_base}) begin
        miss++;
        $display("FAIL cycle_compare t=%0t tick=%b want %b busy=%b want %b base=%b want %b",
                 $time, tick_n, e_tick, busy, e_busy, base_tick, e_base);
      end
    end
  end

  // ---------------- checks and drivers ----------------
  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vec++;
    if (act < lo || act > hi) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic load_cfg(input int ch, input int div, input bit mode);
    load_n = 1'b0; load_sel = 2'(ch); load_div = 8'(div); load_mode = mode;
    @(negedge clk);
    load_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [3:0] mask);
    start_n = ~mask;
    @(negedge clk);
    start_n = 4'hF;
  endtask

  task automatic pulse_stop(input logic [3:0] mask);
    stop_n = ~mask;
    @(negedge clk);
    stop_n = 4'hF;
  endtask

  // n0=0: step first; n0>0: current negedge is already cycle n0
  task automatic wait_tick(input int ch, input int n0, input int limit, output int n);
    n = n0;
    if (n0 == 0) begin @(negedge clk); n = 1; end
    while (tick_n[ch] !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    if (tick_n[ch] !== 1'b0) n = -1;
  endtask

  task automatic wait_base(input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (base_tick !== 1'b1 && n < limit);
    if (base_tick !== 1'b1) n = -1;
  endtask

  task automatic count_ticks(input int ch, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tick_n[ch] === 1'b0) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    int  cnt;
    bit  found;

    #1 rst_n = 1'b0;
    #4;
    check("reset_tick", int'(tick_n), 15);
    check("reset_busy", int'(busy), 0);
    check("reset_base", int'(base_tick), 0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // periodic channel 0: div=2, baseTop=3 -> period 12
    base_top = 27'd3;
    load_cfg(0, 2, 1'b0);
    pulse_start(4'b0001);
    wait_tick(0, 1, 40, n);
    check_range("first_tick_ch0", n, 10, 13);
    check("base_aligned_first", int'(base_tick), 1);
    wait_tick(0, 0, 40, n);
    check("period_ch0", n, 12);
    check("base_aligned_second", int'(base_tick), 1);
    wait_base(20, n);
    check("base_gap", n, 4);
    pulse_stop(4'b0001);

    // one-shot channel 1 with coincident load and start, baseTop=0
    base_top = 27'd0;
    load_n = 1'b0; load_sel = 2'd1; load_div = 8'd4; load_mode = 1'b1;
    start_n = 4'b1101;
    @(negedge clk);
    load_n = 1'b1; start_n = 4'hF;
    wait_tick(1, 1, 20, n);
    check_range("oneshot_delay", n, 5, 6);
    @(negedge clk);
    check("oneshot_busy_fall", int'(busy[1]), 0);
    count_ticks(1, 20, cnt);
    check("oneshot_no_retick", cnt, 0);

    // stop on the expiry strobe of channel 2
    base_top = 27'd3;
    load_cfg(2, 1, 1'b0);
    pulse_start(4'b0100);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run[2] && m_rem[2] == 0 && m_cnt >= int'(base_top)) found = 1'b1;
      else @(negedge clk);
    end
    check("stop_point_found", int'(found), 1);
    pulse_stop(4'b0100);
    check("stop_busy", int'(busy[2]), 0);
    check("stop_no_tick", int'(tick_n[2]), 1);
    count_ticks(2, 12, cnt);
    check("stop_silent", cnt, 0);
    start_n = 4'b1011; stop_n = 4'b1011;
    @(negedge clk);
    start_n = 4'hF; stop_n = 4'hF;
    check("start_stop_idle", int'(busy[2]), 0);

    // channel 3 reconfigured mid-period, baseTop=1
    base_top = 27'd1;
    load_cfg(3, 5, 1'b0);
    pulse_start(4'b1000);
    wait_tick(3, 1, 40, n);
    check_range("ch3_first", n, 12, 13);
    repeat (3) @(negedge clk);
    load_cfg(3, 1, 1'b0);
    wait_tick(3, 4, 40, n);
    check("ch3_old_period", n, 12);
    wait_tick(3, 0, 40, n);
    check("ch3_new_period", n, 4);
    pulse_stop(4'b1000);

    // two channels expiring on the same strobe
    load_cfg(0, 1, 1'b0);
    pulse_start(4'b1001);
    wait_tick(3, 1, 30, n);
    check_range("pair_found", n, 1, 29);
    check("pair_same_cycle", int'(tick_n & 4'b1001), 0);
    pulse_stop(4'b1001);

    // clear mid-run keeps config; restart gives the original period
    base_top = 27'd3;
    load_cfg(0, 2, 1'b0);
    pulse_start(4'b0001);
    repeat (7) @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    check("clear_busy", int'(busy), 0);
    check("clear_tick", int'(tick_n), 15);
    pulse_start(4'b0001);
    wait_tick(0, 1, 40, n);
    check("clear_restart_first", n, 12);
    wait_tick(0, 0, 40, n);
    check("clear_restart_period", n, 12);

    // asynchronous reset mid-run
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tick", int'(tick_n), 15);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_base", int'(base_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) base_top = 27'($urandom_range(0, 4));
      load_n    = ($urandom_range(0, 7) != 0);
      load_sel  = 2'($urandom_range(0, 3));
      load_div  = 8'($urandom_range(0, 6));
      load_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        start_n[i] = ($urandom_range(0, 15) != 0);
        stop_n[i]  = ($urandom_range(0, 39) != 0);
      end
      clear_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 999) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    load_n = 1'b1; start_n = 4'hF; stop_n = 4'hF; clear_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
